// File: rtl/instruction_encoder_if.sv
// instruction_encoder_if
//   Bundles the operator-entry inputs and the instruction-memory write port
//   of instruction_encoder.
//   i_sw      8       switch value sampled on each i_next
//   i_next    1       one-cycle pulse: latch i_sw into current field, advance
//   i_cancel  1       one-cycle pulse: abandon the current entry
//   i_ready   1       memory accepts o_instr this cycle
//   o_instr   32      assembled instruction
//   o_valid   1       o_instr complete and offered
//   o_addr    ADDR_W  write address for o_instr
//   o_state   3       current FSM state, for display
//   o_err     1       one-cycle pulse on an invalid mnemonic code
//   master: the side driving switches/buttons and ready (board / bench)
//   slave : the encoder itself
interface instruction_encoder_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        i_sw;
  logic              i_next;
  logic              i_cancel;
  logic              i_ready;
  logic [31:0]       o_instr;
  logic              o_valid;
  logic [ADDR_W-1:0] o_addr;
  logic [2:0]        o_state;
  logic              o_err;

  modport master (
    output i_sw, i_next, i_cancel, i_ready,
    input  o_instr, o_valid, o_addr, o_state, o_err
  );

  modport slave (
    input  i_sw, i_next, i_cancel, i_ready,
    output o_instr, o_valid, o_addr, o_state, o_err
  );
endinterface

// File: rtl/instruction_encoder.sv
// instruction_encoder
//   Switch-driven MIPS instruction assembler. The operator picks a mnemonic
//   code and enters register / immediate fields one per i_next pulse; the
//   packed 32-bit word is offered on a valid/ready port together with an
//   auto-incrementing write address.
//   i_clk  : rising-edge clock
//   i_rst  : asynchronous active-high reset
//   bus    : instruction_encoder_if.slave (switch inputs, write port, status)
module instruction_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  instruction_encoder_if.slave  bus
);

  localparam logic [2:0] ST_OP   = 3'd0;
  localparam logic [2:0] ST_RS   = 3'd1;
  localparam logic [2:0] ST_RT   = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_IMLO = 3'd4;
  localparam logic [2:0] ST_IMHI = 3'd5;
  localparam logic [2:0] ST_EMIT = 3'd6;

  localparam logic [1:0] KIND_R   = 2'd0;
  localparam logic [1:0] KIND_I   = 2'd1;
  localparam logic [1:0] KIND_J   = 2'd2;
  localparam logic [1:0] KIND_BAD = 2'd3;

  // Instruction class of a mnemonic code; codes 12-15 are unassigned.
  function automatic logic [1:0] code_kind(input logic [3:0] c);
    if (c <= 4'd4)       return KIND_R;
    else if (c <= 4'd10) return KIND_I;
    else if (c == 4'd11) return KIND_J;
    else                 return KIND_BAD;
  endfunction

  function automatic logic [5:0] r_funct(input logic [3:0] c);
    case (c)
      4'd0:    return 6'b100000;
      4'd1:    return 6'b100010;
      4'd2:    return 6'b100100;
      4'd3:    return 6'b100101;
      4'd4:    return 6'b101010;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] i_opcode(input logic [3:0] c);
    case (c)
      4'd5:    return 6'b001000;
      4'd6:    return 6'b001100;
      4'd7:    return 6'b100011;
      4'd8:    return 6'b101011;
      4'd9:    return 6'b000100;
      4'd10:   return 6'b000101;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [31:0] pack(input logic [3:0]  c,
                                       input logic [4:0]  f_rs,
                                       input logic [4:0]  f_rt,
                                       input logic [4:0]  f_rd,
                                       input logic [15:0] f_imm);
    case (code_kind(c))
      KIND_R:  return {6'b000000, f_rs, f_rt, f_rd, 5'b00000, r_funct(c)};
      KIND_I:  return {i_opcode(c), f_rs, f_rt, f_imm};
      KIND_J:  return {6'b000010, 10'b0, f_imm};
      default: return 32'h0;
    endcase
  endfunction

  logic [2:0]        state;
  logic [3:0]        code;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [7:0]        imm_lo;
  logic [31:0]       instr;
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic              err;

  logic [1:0] kind_sw;
  logic [1:0] kind_cur;

  assign kind_sw  = code_kind(bus.i_sw[3:0]);
  assign kind_cur = code_kind(code);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= ST_OP;
      code   <= '0;
      rs     <= '0;
      rt     <= '0;
      imm_lo <= '0;
      instr  <= '0;
      valid  <= 1'b0;
      addr   <= '0;
      err    <= 1'b0;
    end else begin
      err <= 1'b0;
      // A completed handshake beats a simultaneous cancel: the word commits.
      if (valid && bus.i_ready) begin
        valid <= 1'b0;
        state <= ST_OP;
        addr  <= addr + 1'b1;
      end else if (bus.i_cancel) begin
        valid  <= 1'b0;
        state  <= ST_OP;
        code   <= '0;
        rs     <= '0;
        rt     <= '0;
        imm_lo <= '0;
      end else if (bus.i_next) begin
        case (state)
          ST_OP: begin
            if (kind_sw == KIND_BAD) begin
              err <= 1'b1;
            end else begin
              code  <= bus.i_sw[3:0];
              state <= (kind_sw == KIND_J) ? ST_IMLO : ST_RS;
            end
          end
          ST_RS: begin
            rs    <= bus.i_sw[4:0];
            state <= ST_RT;
          end
          ST_RT: begin
            rt    <= bus.i_sw[4:0];
            state <= (kind_cur == KIND_R) ? ST_RD : ST_IMLO;
          end
          ST_RD: begin
            // Final R-type field goes straight into the word so o_valid
            // rises on this same edge.
            instr <= pack(code, rs, rt, bus.i_sw[4:0], 16'h0);
            valid <= 1'b1;
            state <= ST_EMIT;
          end
          ST_IMLO: begin
            imm_lo <= bus.i_sw;
            state  <= ST_IMHI;
          end
          ST_IMHI: begin
            instr <= pack(code, rs, rt, 5'd0, {bus.i_sw, imm_lo});
            valid <= 1'b1;
            state <= ST_EMIT;
          end
          default: ; // EMIT holds the word; i_next has no effect
        endcase
      end
    end
  end

  assign bus.o_instr = instr;
  assign bus.o_valid = valid;
  assign bus.o_addr  = addr;
  assign bus.o_state = state;
  assign bus.o_err   = err;

endmodule
